// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage and the writeback stage.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package mem_stage_pkg;

    // Major opcodes that touch data memory
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Access size lives in funct3[1:0]; funct3[2] selects zero-extension on loads
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_LDX = 3'b111;  // no such encoding; behaves as LD

    // Control-store bit positions shared with writeback
    localparam int CST_RWE = 0;   // register write enable
    localparam int CST_WOP = 17;  // 32-bit W-op

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } mem_state_e;

    // Byte-lane mask for an access of the given size, before lane shifting
    function automatic logic [7:0] size_mask(input logic [1:0] sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data aligner: shifts the addressed bytes to lane 0 and sign/zero-extends.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (memory doubleword), off (byte offset), funct3 (size/sign), result.
module load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] w_raw;

    assign w_raw = rdata >> {off, 3'b000};

    always_comb begin
        result = w_raw;
        case (funct3)
            F3_LB:   result = {{(XLEN-8){w_raw[7]}},   w_raw[7:0]};
            F3_LH:   result = {{(XLEN-16){w_raw[15]}}, w_raw[15:0]};
            F3_LW:   result = {{(XLEN-32){w_raw[31]}}, w_raw[31:0]};
            F3_LBU:  result = {{(XLEN-8){1'b0}},       w_raw[7:0]};
            F3_LHU:  result = {{(XLEN-16){1'b0}},      w_raw[15:0]};
            F3_LWU:  result = {{(XLEN-32){1'b0}},      w_raw[31:0]};
            default: result = w_raw;  // LD and the unused 111 encoding
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores, aligns load data, registers the WB latch.
// Latency: 1 cycle MEM->WB without wait states; N+1 cycles when memory inserts N wait cycles.
// Backpressure: MEM_STALL holds all upstream stages while an access is outstanding.
// Ports: MEM_* execute-side inputs, FLUSH kill, DMEM_* request/ready memory port,
//        MEM_STALL upstream hold, WB_* registered outputs consumed by writeback.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CST_W = 19
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             MEM_V,
    input  logic [CST_W-1:0] MEM_Cst,
    input  logic [XLEN-1:0]  MEM_ALU_RES,
    input  logic [XLEN-1:0]  MEM_RFD,
    input  logic [31:0]      MEM_IR,
    input  logic [XLEN-1:0]  MEM_NPC,
    input  logic [XLEN-1:0]  MEM_Target_Address,
    input  logic [XLEN-1:0]  MEM_CSRFD,
    input  logic             MEM_PC_MUX,
    input  logic             FLUSH,
    output logic             DMEM_REQ,
    output logic             DMEM_WE,
    output logic [XLEN-1:0]  DMEM_ADDR,
    output logic [XLEN-1:0]  DMEM_WDATA,
    output logic [7:0]       DMEM_BE,
    input  logic [XLEN-1:0]  DMEM_RDATA,
    input  logic             DMEM_READY,
    output logic             MEM_STALL,
    output logic             WB_V,
    output logic             WB_PC_MUX,
    output logic             WB_LAM,
    output logic             WB_SAM,
    output logic [CST_W-1:0] WB_Cst,
    output logic [31:0]      WB_IR,
    output logic [XLEN-1:0]  WB_RES,
    output logic [XLEN-1:0]  WB_NPC,
    output logic [XLEN-1:0]  WB_Target_Address,
    output logic [XLEN-1:0]  WB_CSRFD,
    output logic [XLEN-1:0]  WB_RFD
);

    mem_state_e       r_state;
    mem_state_e       w_state_nxt;

    logic [2:0]       w_f3;
    logic [1:0]       w_size;
    logic [2:0]       w_off;
    logic             w_is_load;
    logic             w_is_store;
    logic             w_mis;
    logic             w_mis_any;
    logic             w_go;
    logic             w_req;
    logic             w_stall;
    logic             w_kill;
    logic [7:0]       w_be_base;
    logic [XLEN-1:0]  w_ld_res;
    logic [CST_W-1:0] w_cst;

    // ---------------- decode / alignment ----------------
    assign w_f3       = MEM_IR[14:12];
    assign w_size     = w_f3[1:0];
    assign w_off      = MEM_ALU_RES[2:0];
    assign w_is_load  = MEM_V && (MEM_IR[6:0] == OP_LOAD);
    assign w_is_store = MEM_V && (MEM_IR[6:0] == OP_STORE);

    assign w_mis = ((w_size == SZ_H) &&  w_off[0])
                || ((w_size == SZ_W) && (w_off[1:0] != 2'b00))
                || ((w_size == SZ_D) && (w_off != 3'b000));

    assign w_mis_any = (w_is_load || w_is_store) && w_mis;
    assign w_go      = (w_is_load || w_is_store) && !w_mis && !FLUSH;

    // ---------------- memory port ----------------
    // Request attributes are pure functions of MEM inputs, which upstream holds
    // steady under MEM_STALL, so they stay stable for the life of a request.
    assign w_be_base  = size_mask(w_size);
    assign DMEM_REQ   = w_req;
    assign DMEM_WE    = w_is_store;
    assign DMEM_ADDR  = {MEM_ALU_RES[XLEN-1:3], 3'b000};
    assign DMEM_WDATA = MEM_RFD << {w_off, 3'b000};
    assign DMEM_BE    = w_be_base << w_off;
    assign MEM_STALL  = w_stall;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (DMEM_RDATA),
        .off    (w_off),
        .funct3 (w_f3),
        .result (w_ld_res)
    );

    // ---------------- access FSM ----------------
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_kill      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_req = 1'b1;
                    if (!DMEM_READY) begin
                        w_stall     = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // FLUSH together with READY needs no special case: the WB
                // latch already turns FLUSH into a bubble.
                w_req = 1'b1;
                if (DMEM_READY) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (FLUSH) w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Request cannot be withdrawn; wait it out and drop the data.
                // FLUSH has already passed, so the bubble is forced here.
                w_req  = 1'b1;
                w_kill = 1'b1;
                if (DMEM_READY) w_state_nxt = ST_IDLE;
                else            w_stall     = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (RESET) begin
            w_req   = 1'b0;
            w_stall = 1'b0;
        end
    end

    // Misaligned accesses must not write the register file
    always_comb begin
        w_cst          = MEM_Cst;
        w_cst[CST_RWE] = MEM_Cst[CST_RWE] && !w_mis_any;
    end

    // ---------------- WB latch ----------------
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WB_V              <= 1'b0;
            WB_PC_MUX         <= 1'b0;
            WB_LAM            <= 1'b0;
            WB_SAM            <= 1'b0;
            WB_Cst            <= '0;
            WB_IR             <= '0;
            WB_RES            <= '0;
            WB_NPC            <= '0;
            WB_Target_Address <= '0;
            WB_CSRFD          <= '0;
            WB_RFD            <= '0;
        end else if (w_stall) begin
            WB_V <= 1'b0;
        end else begin
            WB_V              <= MEM_V && !FLUSH && !w_kill;
            WB_PC_MUX         <= MEM_PC_MUX;
            WB_LAM            <= w_is_load  && w_mis && !FLUSH;
            WB_SAM            <= w_is_store && w_mis && !FLUSH;
            WB_Cst            <= w_cst;
            WB_IR             <= MEM_IR;
            // A misaligned load has no data; the faulting address is more useful to a trap handler
            WB_RES            <= (w_is_load && !w_mis) ? w_ld_res : MEM_ALU_RES;
            WB_NPC            <= MEM_NPC;
            WB_Target_Address <= MEM_Target_Address;
            WB_CSRFD          <= MEM_CSRFD;
            WB_RFD            <= MEM_RFD;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam logic [6:0] T_LOAD  = 7'b0000011;
    localparam logic [6:0] T_STORE = 7'b0100011;
    localparam logic [6:0] T_ALU   = 7'b0110011;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_V;
    logic [18:0] MEM_Cst;
    logic [63:0] MEM_ALU_RES, MEM_RFD, MEM_NPC, MEM_Target_Address, MEM_CSRFD;
    logic [31:0] MEM_IR;
    logic        MEM_PC_MUX, FLUSH;
    logic        DMEM_REQ, DMEM_WE;
    logic [63:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [7:0]  DMEM_BE;
    logic        DMEM_READY, MEM_STALL;
    logic        WB_V, WB_PC_MUX, WB_LAM, WB_SAM;
    logic [18:0] WB_Cst;
    logic [31:0] WB_IR;
    logic [63:0] WB_RES, WB_NPC, WB_Target_Address, WB_CSRFD, WB_RFD;

    mem_stage dut (
        .CLK(CLK), .RESET(RESET), .MEM_V(MEM_V), .MEM_Cst(MEM_Cst),
        .MEM_ALU_RES(MEM_ALU_RES), .MEM_RFD(MEM_RFD), .MEM_IR(MEM_IR),
        .MEM_NPC(MEM_NPC), .MEM_Target_Address(MEM_Target_Address),
        .MEM_CSRFD(MEM_CSRFD), .MEM_PC_MUX(MEM_PC_MUX), .FLUSH(FLUSH),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_READY(DMEM_READY), .MEM_STALL(MEM_STALL),
        .WB_V(WB_V), .WB_PC_MUX(WB_PC_MUX), .WB_LAM(WB_LAM), .WB_SAM(WB_SAM),
        .WB_Cst(WB_Cst), .WB_IR(WB_IR), .WB_RES(WB_RES), .WB_NPC(WB_NPC),
        .WB_Target_Address(WB_Target_Address), .WB_CSRFD(WB_CSRFD), .WB_RFD(WB_RFD)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        res_chk;
        logic [63:0] res;
        logic [18:0] cst;
        logic        lam, sam, pcm;
        logic [31:0] ir;
        logic [63:0] npc, tgt, csr, rfd;
    } wb_t;

    wb_t exp_q[$];
    wb_t mon_e;
    int  n_chk  = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference load: gather the addressed bytes one by one, then extend
    function automatic logic [63:0] model_load(input logic [63:0] rd, input int off, input logic [2:0] f3);
        int          nb = 1 << f3[1:0];
        logic [63:0] v  = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!f3[2] && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // Scoreboard monitor: every valid WB beat must match the oldest expectation
    always @(negedge CLK) begin
        if (RESET === 1'b0 && WB_V === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.res_chk) chk("wb_res", WB_RES, mon_e.res);
                chk("wb_cst",   64'(WB_Cst), 64'(mon_e.cst));
                chk("wb_flags", {61'd0, WB_LAM, WB_SAM, WB_PC_MUX}, {61'd0, mon_e.lam, mon_e.sam, mon_e.pcm});
                chk("wb_ir",    64'(WB_IR), 64'(mon_e.ir));
                chk("wb_npc",   WB_NPC, mon_e.npc);
                chk("wb_tgt",   WB_Target_Address, mon_e.tgt);
                chk("wb_csr",   WB_CSRFD, mon_e.csr);
                chk("wb_rfd",   WB_RFD, mon_e.rfd);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK); #1;
            MEM_V = 1'b0; FLUSH = 1'b0; DMEM_READY = 1'b0;
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [6:0] opc, input logic [2:0] f3);
        logic [16:0] hi = 17'($urandom);
        logic [4:0]  rd = 5'($urandom);
        return {hi, f3, rd, opc};
    endfunction

    // One instruction through MEM. lat = cycle index of DMEM_READY, fl = cycle index of FLUSH (-1 none)
    task automatic run_op(input logic [31:0] ir, input logic [63:0] addr, input logic [63:0] rfd,
                          input logic [63:0] rd, input int lat, input int fl);
        logic [6:0]  opc = ir[6:0];
        logic [2:0]  f3  = ir[14:12];
        int          nb  = 1 << f3[1:0];
        int          off = int'(addr[2:0]);
        bit          ld  = (opc == T_LOAD);
        bit          st  = (opc == T_STORE);
        bit          mis = (ld || st) && (off % nb != 0);
        bit          iss = (ld || st) && !mis && (fl != 0);
        int          nlast = iss ? lat : 0;
        bit          valid = !(fl >= 0 && fl <= nlast);
        logic [7:0]  be  = '0;
        logic [63:0] wd  = '0;
        wb_t         e;
        logic [18:0] cst = 19'($urandom);
        logic [63:0] npc = {$urandom, $urandom};
        logic [63:0] tgt = {$urandom, $urandom};
        logic [63:0] csr = {$urandom, $urandom};
        logic        pcm = 1'($urandom);

        for (int i = 0; i < nb && off + i < 8; i++) be[off+i] = 1'b1;
        for (int i = 0; i < 8; i++) if (i >= off) wd[8*i +: 8] = rfd[8*(i-off) +: 8];

        e.res_chk = !mis;
        e.res = (ld && !mis) ? model_load(rd, off, f3) : addr;
        e.cst = cst;
        if (mis) e.cst[0] = 1'b0;
        e.lam = ld && mis; e.sam = st && mis; e.pcm = pcm;
        e.ir = ir; e.npc = npc; e.tgt = tgt; e.csr = csr; e.rfd = rfd;
        if (valid) exp_q.push_back(e);

        for (int c = 0; c <= nlast; c++) begin
            @(posedge CLK); #1;
            MEM_V = 1'b1; MEM_IR = ir; MEM_ALU_RES = addr; MEM_RFD = rfd; MEM_Cst = cst;
            MEM_NPC = npc; MEM_Target_Address = tgt; MEM_CSRFD = csr; MEM_PC_MUX = pcm;
            FLUSH      = (c == fl);
            DMEM_READY = iss && (c == lat);
            DMEM_RDATA = (c == lat) ? rd : {$urandom, $urandom};
            @(negedge CLK);
            chk("dmem_req",  64'(DMEM_REQ),  64'(iss));
            chk("mem_stall", 64'(MEM_STALL), 64'(iss && c < lat));
            if (iss) begin
                chk("dmem_addr",  DMEM_ADDR, {addr[63:3], 3'b000});
                chk("dmem_we",    64'(DMEM_WE), 64'(st));
                chk("dmem_be",    64'(DMEM_BE), 64'(be));
                chk("dmem_wdata", DMEM_WDATA, wd);
            end
            if (c > 0) chk("wb_bubble", 64'(WB_V), 64'd0);
        end
    endtask

    initial begin
        RESET = 1'b1; MEM_V = 1'b0; MEM_Cst = '0; MEM_ALU_RES = '0; MEM_RFD = '0; MEM_IR = '0;
        MEM_NPC = '0; MEM_Target_Address = '0; MEM_CSRFD = '0; MEM_PC_MUX = 1'b0; FLUSH = 1'b0;
        DMEM_RDATA = '0; DMEM_READY = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_wb_v",  64'(WB_V), 64'd0);
        chk("rst_wb_res", WB_RES, 64'd0);
        chk("rst_req",   64'(DMEM_REQ), 64'd0);
        chk("rst_stall", 64'(MEM_STALL), 64'd0);
        @(posedge CLK); #1; RESET = 1'b0;

        // Directed cases from the plan
        run_op(mk_ir(T_LOAD, 3'b000), 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 0, -1);
        idle(1);
        @(negedge CLK);
        chk("lb_plan_res", WB_RES, 64'hFFFF_FFFF_FFFF_FF80);
        run_op(mk_ir(T_STORE, 3'b001), 64'h2006, 64'hABCD, 64'h0, 0, -1);
        run_op(mk_ir(T_LOAD, 3'b010), 64'h3004, 64'h0, 64'h8765_4321_0F0E_0D0C, 3, -1);
        run_op(mk_ir(T_LOAD, 3'b011), 64'h1004, 64'h0, 64'h0, 0, -1);
        run_op(mk_ir(T_LOAD, 3'b010), 64'h5008, 64'h0, 64'h1111_2222_3333_4444, 4, 2);
        run_op(mk_ir(T_LOAD, 3'b110), 64'h600C, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 2);
        run_op(mk_ir(T_STORE, 3'b011), 64'h7000, 64'h1234, 64'h0, 1, 0);
        run_op(mk_ir(T_LOAD, 3'b111), 64'h7010, 64'h0, 64'h8000_0000_0000_0001, 1, -1);
        idle(2);

        // Reset in the middle of an outstanding access
        @(posedge CLK); #1;
        MEM_V = 1'b1; MEM_IR = mk_ir(T_LOAD, 3'b010); MEM_ALU_RES = 64'h4000; FLUSH = 1'b0; DMEM_READY = 1'b0;
        @(negedge CLK); chk("rst_mid_req0", 64'(DMEM_REQ), 64'd1);
        @(posedge CLK); #1;
        @(negedge CLK); chk("rst_mid_wait_stall", 64'(MEM_STALL), 64'd1);
        @(posedge CLK); #1; RESET = 1'b1;
        @(posedge CLK); #1; RESET = 1'b0; MEM_V = 1'b0;
        @(negedge CLK);
        chk("rst_mid_req",   64'(DMEM_REQ), 64'd0);
        chk("rst_mid_stall", 64'(MEM_STALL), 64'd0);
        chk("rst_mid_wb",    {WB_RES | WB_NPC | WB_Target_Address | WB_CSRFD | WB_RFD},  64'd0);
        chk("rst_mid_wb2",   {13'd0, WB_V, WB_PC_MUX, WB_LAM, WB_SAM, WB_Cst, WB_IR}, 64'd0);
        // A flushed op in IDLE issues nothing; a stuck WAIT would keep requesting
        run_op(mk_ir(T_LOAD, 3'b010), 64'h4000, 64'h0, 64'h0, 1, 0);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            int          k   = int'($urandom_range(0, 3));
            logic [2:0]  f3  = 3'($urandom);
            logic [6:0]  opc = (k == 0) ? T_ALU : (k == 3) ? T_STORE : T_LOAD;
            logic [63:0] a   = {$urandom, $urandom};
            int          lat = int'($urandom_range(0, 3));
            int          fl  = -1;
            if (k == 3) f3[2] = 1'b0;
            if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'((1 << f3[1:0]) - 1);
            if ($urandom_range(0, 9) == 0) fl = int'($urandom_range(0, lat));
            run_op(mk_ir(opc, f3), a, {$urandom, $urandom}, {$urandom, $urandom}, lat, fl);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        idle(3);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between execute and `writeback`. It issues loads and stores to the data memory through a request/ready handshake and aligns and sign-extends load data. It generates byte enables and detects misaligned accesses, and registers everything into the `WB_*` latch that `writeback` consumes. While a memory access is outstanding it stalls the upstream pipeline.

## Interface
Parameters:
- `XLEN`, 64, datapath width
- `CST_W`, 19, control-store width

Ports:
- `CLK`  in  1  clock; all state updates on rising edge
- `RESET`  in  1  synchronous, active-high reset
- `MEM_V`  in  1  valid instruction in MEM
- `MEM_Cst`  in  19  control store; bit 0 = reg write enable, bit 17 = W-op
- `MEM_ALU_RES`  in  64  ALU result; this is the effective address for loads/stores
- `MEM_RFD`  in  64  rs2 data (store source)
- `MEM_IR`  in  32  instruction
- `MEM_NPC`, `MEM_Target_Address`, `MEM_CSRFD`  in  64 each  pass-through
- `MEM_PC_MUX`  in  1  pass-through
- `FLUSH`  in  1  trap/redirect kill of the MEM instruction
- `DMEM_REQ`  out  1  memory request
- `DMEM_WE`  out  1  1 = store
- `DMEM_ADDR`  out  64  `{MEM_ALU_RES[63:3], 3'b000}`
- `DMEM_WDATA`  out  64  lane-shifted store data
- `DMEM_BE`  out  8  byte enables
- `DMEM_RDATA`  in  64  read data, valid with `DMEM_READY`
- `DMEM_READY`  in  1  access complete this cycle
- `MEM_STALL`  out  1  hold all upstream stages
- `WB_V`, `WB_PC_MUX`, `WB_LAM`, `WB_SAM`  out  1 each  registered
- `WB_Cst`  out  19  registered
- `WB_IR`  out  32  registered
- `WB_RES`, `WB_NPC`, `WB_Target_Address`, `WB_CSRFD`, `WB_RFD`  out  64 each  registered

## Operation
- Memory op decode: `MEM_IR[6:0]` = 0000011 is a load, 0100011 is a store. Size and sign come from `MEM_IR[14:12]`.
- `off = MEM_ALU_RES[2:0]`.
- Misaligned conditions: half-word with `off[0]` set; word with `off[1:0]` ≠ 0; double-word with `off` ≠ 0.
- A misaligned access issues no request. It latches with `WB_V=1`, `WB_LAM` or `WB_SAM` = 1, and `WB_Cst[0]` forced to 0.
- Store path:
  - `DMEM_WDATA = MEM_RFD << 8*off`.
  - `DMEM_BE = {1,3,F,FF}[size] << off`, truncated to 8 bits.
- Load path:
  - `raw = DMEM_RDATA >> 8*off`.
  - LB/LH/LW/LD sign-extend from bit 7/15/31/63.
  - LBU/LHU/LWU zero-extend.
  - funct3 111 is treated as LD.
- `WB_RES` = load result for loads, `MEM_ALU_RES` otherwise.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE, with a valid aligned memory op and no `FLUSH`:
    - `DMEM_REQ=1`.
    - If `DMEM_READY` is high the same cycle, latch to WB and stay in IDLE.
    - Otherwise assert `MEM_STALL` and go to WAIT.
  - WAIT: hold `DMEM_REQ`; `MEM_STALL=1`. Upstream holds the inputs stable.
    - On `DMEM_READY`: latch to WB, deassert the stall, go to IDLE.
    - If `FLUSH` arrives (without `DMEM_READY`), go to DRAIN.
  - DRAIN: keep `DMEM_REQ=1` and `MEM_STALL=1`. On `DMEM_READY`, discard the data, latch a bubble (`WB_V=0`), go to IDLE.
- WB latch:
  - Loads when `MEM_STALL=0`.
  - `WB_V <= MEM_V & ~FLUSH`.
  - While stalled, the latch loads a bubble (`WB_V <= 0`; other fields hold).
- `FLUSH` in IDLE suppresses the request.

## Timing
- Non-memory ops and stores/loads with same-cycle ready: 1-cycle latency, MEM to WB.
- Load/store with N wait cycles: N+1 cycles; `MEM_STALL` is high for N cycles.
- `DMEM_ADDR`, `DMEM_WE`, `DMEM_WDATA`, `DMEM_BE` stay stable while `DMEM_REQ` is high.
- A request is never withdrawn before `DMEM_READY`.
- `FLUSH` and `DMEM_READY` in the same WAIT cycle: the data is discarded, a bubble is latched, and the FSM goes to IDLE.
- Reset values:
  - State = IDLE.
  - All `WB_*` = 0.
  - `DMEM_REQ=0`, `MEM_STALL=0`.
- Reset mid-access abandons the outstanding request. The memory model must tolerate this.

## Structure
- Shared package holds:
  - opcode constants `OP_LOAD`, `OP_STORE`;
  - funct3 size codes;
  - the FSM state encoding (2 bits);
  - `Cst` bit-index defines shared with `writeback`.
- Sub-module `load_align`: purely combinational. Inputs are `rdata`, `off`, `funct3`; output is the 64-bit extended result.
- Byte-enable generation, misalignment detection and the FSM stay in `mem_stage`.

## Test plan
- LB, `MEM_ALU_RES=0x1003`, `DMEM_RDATA=0x00000000_80000000`, `DMEM_READY` same cycle → `WB_RES=0xFFFF_FFFF_FFFF_FF80`, `WB_V=1`, no stall.
- SH, addr `0x2006`, `MEM_RFD=0xABCD` → `DMEM_BE=0xC0`, `DMEM_WDATA[63:48]=0xABCD`, `DMEM_WE=1`, `DMEM_ADDR=0x2000`.
- LW with `DMEM_READY` delayed 3 cycles → `MEM_STALL` high for exactly 3 cycles. WB receives 3 bubbles and then the load with the correct `WB_RES`.
- LD at addr `0x1004` → no `DMEM_REQ`; `WB_LAM=1`, `WB_V=1`, `WB_Cst[0]=0`.
- `FLUSH` in cycle 2 of WAIT, ready in cycle 4 → DRAIN holds `DMEM_REQ`; `WB_V=0`; stall drops after ready.
- `RESET` asserted while in WAIT → next cycle state is IDLE, `DMEM_REQ=0`, all `WB_*` = 0.
